fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I pipeline. Consumes the branch/jump `flush` and redirect target resolved in EX, and the load-use `stall` from the hazard unit. Drives the word address of the synchronous-read instruction BRAM and presents `{PC, PC+4, instruction, valid}` to ID. Squashing of ID/EX on a flush is handled outside this block; this block squashes only IF/ID.

---
 rtl/fetch_stage_if.sv | 19 +
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a synchronous-read BRAM.
// The fetch stage presents a word address; the BRAM registers it and returns
// the addressed word on the following cycle.
interface fetch_stage_if #(
    parameter int IMEM_AW = 10
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage RV32I core.
// Selects the next PC (reset / halt / redirect / stall / sequential), drives the
// BRAM word address from that next PC so the read data lines up with pc_q, and
// loads IF/ID with either the fetched instruction or a NOP bubble. A misaligned
// redirect target parks the stage in HALT until reset.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              IMEM_AW  = 10,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [XLEN-1:0]  target_EX,
    input  logic             stall,
    fetch_stage_if.master    imem,
    output logic [XLEN-1:0]  PC_IF,
    output logic [XLEN-1:0]  PC_IF_ID,
    output logic [XLEN-1:0]  PC4_IF_ID,
    output logic [31:0]      instr_IF_ID,
    output logic             valid_IF_ID,
    output logic             misalign_err,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_id_q, pc_id_d;
    logic [XLEN-1:0]  pc4_id_q, pc4_id_d;
    logic [31:0]      instr_id_q, instr_id_d;
    logic             valid_id_q, valid_id_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-PC selection, IF/ID load, halt entry and counter updates, in priority order.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        pc_d        = pc_plus4;
        pc_id_d     = pc_id_q;
        pc4_id_d    = pc4_id_q;
        instr_id_d  = instr_id_q;
        valid_id_d  = valid_id_q;
        state_d     = state_q;
        misalign_d  = misalign_q;
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (reset) begin
            pc_d = RESET_PC;
        end else if (state_q == ST_HALT) begin
            pc_d       = pc_q;
            pc_id_d    = '0;
            pc4_id_d   = '0;
            instr_id_d = NOP;
            valid_id_d = 1'b0;
        end else if (flush) begin
            // Redirect beats a simultaneous stall; the wrong-path fetch becomes a bubble.
            pc_d       = target_EX;
            pc_id_d    = '0;
            pc4_id_d   = '0;
            instr_id_d = NOP;
            valid_id_d = 1'b0;
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
            if (target_EX[1:0] != 2'b00) begin
                state_d    = ST_HALT;
                misalign_d = 1'b1;
            end
        end else if (stall) begin
            // Re-present pc_q so the BRAM output is still mem[pc_q] when the stall drops.
            pc_d = pc_q;
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            pc_id_d    = pc_q;
            pc4_id_d   = pc_plus4;
            instr_id_d = imem.imem_rdata;
            valid_id_d = 1'b1;
        end
    end

    // The BRAM registers the next PC, so its data belongs to pc_q one cycle later.
    assign imem.imem_addr = pc_d[IMEM_AW+1:2];

    // State register with synchronous reset to the bubble / RESET_PC state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            pc_id_q     <= '0;
            pc4_id_q    <= '0;
            instr_id_q  <= NOP;
            valid_id_q  <= 1'b0;
            misalign_q  <= 1'b0;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_id_q     <= pc_id_d;
            pc4_id_q    <= pc4_id_d;
            instr_id_q  <= instr_id_d;
            valid_id_q  <= valid_id_d;
            misalign_q  <= misalign_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC_IF        = pc_q;
    assign PC_IF_ID     = pc_id_q;
    assign PC4_IF_ID    = pc4_id_q;
    assign instr_IF_ID  = instr_id_q;
    assign valid_IF_ID  = valid_id_q;
    assign misalign_err = misalign_q;
    assign flush_cnt    = flush_cnt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a default instance (IMEM_AW=10, RESET_PC=0)
// and a small instance (IMEM_AW=4, RESET_PC=0x3C, 2-bit counters) for address
// wrap and counter saturation. Each instance has its own BRAM model.
module tb_fetch_stage;

    localparam logic [96:0] BUBBLE = {1'b0, 32'h0000_0013, 32'h0, 32'h0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- default instance ----------------
    logic        reset, flush, stall;
    logic [31:0] target_EX;
    logic [31:0] PC_IF, PC_IF_ID, PC4_IF_ID, instr_IF_ID, flush_cnt, stall_cnt;
    logic        valid_IF_ID, misalign_err;
    logic [31:0] mem [0:1023];

    fetch_stage_if #(.IMEM_AW(10)) bus ();

    fetch_stage #(.XLEN(32), .IMEM_AW(10), .RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .target_EX(target_EX), .stall(stall),
        .imem(bus), .PC_IF(PC_IF), .PC_IF_ID(PC_IF_ID), .PC4_IF_ID(PC4_IF_ID),
        .instr_IF_ID(instr_IF_ID), .valid_IF_ID(valid_IF_ID), .misalign_err(misalign_err),
        .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
    );

    // Synchronous-read BRAM model
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    // ---------------- small instance ----------------
    logic        reset2, flush2, stall2;
    logic [31:0] target2;
    logic [31:0] PC_IF2, PC_IF_ID2, PC4_IF_ID2, instr_IF_ID2;
    logic        valid_IF_ID2, misalign_err2;
    logic [1:0]  flush_cnt2, stall_cnt2;
    logic [31:0] mem2 [0:15];

    fetch_stage_if #(.IMEM_AW(4)) bus2 ();

    fetch_stage #(.XLEN(32), .IMEM_AW(4), .RESET_PC(32'h3C), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .flush(flush2), .target_EX(target2), .stall(stall2),
        .imem(bus2), .PC_IF(PC_IF2), .PC_IF_ID(PC_IF_ID2), .PC4_IF_ID(PC4_IF_ID2),
        .instr_IF_ID(instr_IF_ID2), .valid_IF_ID(valid_IF_ID2), .misalign_err(misalign_err2),
        .flush_cnt(flush_cnt2), .stall_cnt(stall_cnt2)
    );

    always @(posedge clk) bus2.imem_rdata <= mem2[bus2.imem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [96:0] ifid();
        return {valid_IF_ID, instr_IF_ID, PC_IF_ID, PC4_IF_ID};
    endfunction

    function automatic logic [96:0] ifid_exp(input logic [31:0] pc);
        return {1'b1, mem[pc[11:2]], pc, pc + 32'd4};
    endfunction

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; stall = 1'b0; target_EX = '0;
        tick(); tick();
        checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL reset_imem_addr: got %0d exp 0", bus.imem_addr); end
        checks++; if (ifid() !== BUBBLE) begin errors++; $display("FAIL reset_ifid: got %h exp %h", ifid(), BUBBLE); end
        checks++; if ({misalign_err, flush_cnt, stall_cnt} !== 65'd0) begin errors++; $display("FAIL reset_status: got %b/%0d/%0d exp 0/0/0", misalign_err, flush_cnt, stall_cnt); end
        reset = 1'b0;
        #1;
        checks++; if ({PC_IF, valid_IF_ID} !== {32'h0, 1'b0}) begin errors++; $display("FAIL release_cycle1: got pc %h valid %b exp 0/0", PC_IF, valid_IF_ID); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifid() !== ifid_exp(32'(i * 4))) begin errors++; $display("FAIL seq_ifid[%0d]: got %h exp %h", i, ifid(), ifid_exp(32'(i * 4))); end
            checks++; if (PC_IF !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, PC_IF, 32'(i * 4 + 4)); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({ifid(), PC_IF} !== {ifid_exp(32'h8), 32'hC}) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%h exp %h/%h", i, ifid(), PC_IF, ifid_exp(32'h8), 32'hC); end
        end
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt: got %0d exp 3", stall_cnt); end
        stall = 1'b0;
        tick();
        checks++; if (ifid() !== ifid_exp(32'hC)) begin errors++; $display("FAIL stall_release: got %h exp %h", ifid(), ifid_exp(32'hC)); end
    endtask

    task automatic test_flush();
        flush = 1'b1; target_EX = 32'h40;
        tick();
        flush = 1'b0;
        checks++; if ({PC_IF, ifid()} !== {32'h40, BUBBLE}) begin errors++; $display("FAIL flush_bubble: got %h/%h exp 40/%h", PC_IF, ifid(), BUBBLE); end
        checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL flush_cnt: got %0d exp 1", flush_cnt); end
        tick();
        checks++; if (ifid() !== {1'b1, 32'h00100093 + 32'd16, 32'h40, 32'h44}) begin errors++; $display("FAIL flush_target: got %h", ifid()); end
    endtask

    task automatic test_flush_and_stall();
        flush = 1'b1; stall = 1'b1; target_EX = 32'h80;
        tick();
        flush = 1'b0; stall = 1'b0;
        checks++; if ({PC_IF, ifid()} !== {32'h80, BUBBLE}) begin errors++; $display("FAIL fs_bubble: got %h/%h exp 80/%h", PC_IF, ifid(), BUBBLE); end
        checks++; if ({flush_cnt, stall_cnt} !== {32'd2, 32'd3}) begin errors++; $display("FAIL fs_counters: got %0d/%0d exp 2/3", flush_cnt, stall_cnt); end
        tick();
        checks++; if (ifid() !== ifid_exp(32'h80)) begin errors++; $display("FAIL fs_target: got %h exp %h", ifid(), ifid_exp(32'h80)); end
    endtask

    task automatic test_back_to_back();
        flush = 1'b1; target_EX = 32'h100;
        tick();
        checks++; if ({PC_IF, ifid()} !== {32'h100, BUBBLE}) begin errors++; $display("FAIL b2b_first: got %h/%h exp 100/%h", PC_IF, ifid(), BUBBLE); end
        target_EX = 32'h200;
        tick();
        flush = 1'b0;
        checks++; if ({PC_IF, ifid()} !== {32'h200, BUBBLE}) begin errors++; $display("FAIL b2b_second: got %h/%h exp 200/%h", PC_IF, ifid(), BUBBLE); end
        tick();
        checks++; if (ifid() !== ifid_exp(32'h200)) begin errors++; $display("FAIL b2b_target: got %h exp %h", ifid(), ifid_exp(32'h200)); end
        checks++; if (flush_cnt !== 32'd4) begin errors++; $display("FAIL b2b_cnt: got %0d exp 4", flush_cnt); end
    endtask

    task automatic test_misalign_halt();
        flush = 1'b1; target_EX = 32'h42;
        tick();
        flush = 1'b0;
        checks++; if ({misalign_err, PC_IF, ifid()} !== {1'b1, 32'h42, BUBBLE}) begin errors++; $display("FAIL misalign: got %b/%h/%h exp 1/42/%h", misalign_err, PC_IF, ifid(), BUBBLE); end
        flush = 1'b1; stall = 1'b1; target_EX = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({PC_IF, ifid(), flush_cnt, stall_cnt} !== {32'h42, BUBBLE, 32'd5, 32'd3}) begin errors++; $display("FAIL halt_hold[%0d]: got %h/%h/%0d/%0d exp 42/bubble/5/3", i, PC_IF, ifid(), flush_cnt, stall_cnt); end
        end
        reset = 1'b1;
        #1;
        checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL halt_reset_addr: got %0d exp 0", bus.imem_addr); end
        tick();
        checks++; if ({PC_IF, ifid(), misalign_err, flush_cnt, stall_cnt} !== {32'h0, BUBBLE, 1'b0, 32'd0, 32'd0}) begin errors++; $display("FAIL halt_reset: got %h/%h/%b/%0d/%0d", PC_IF, ifid(), misalign_err, flush_cnt, stall_cnt); end
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        tick(); tick();
        checks++; if (ifid() !== ifid_exp(32'h4)) begin errors++; $display("FAIL halt_restart: got %h exp %h", ifid(), ifid_exp(32'h4)); end
    endtask

    task automatic test_addr_wrap();
        reset2 = 1'b1;
        tick(); tick();
        checks++; if ({bus2.imem_addr, PC_IF2} !== {4'd15, 32'h3C}) begin errors++; $display("FAIL wrap_reset: got %0d/%h exp 15/3c", bus2.imem_addr, PC_IF2); end
        reset2 = 1'b0;
        #1;
        checks++; if ({bus2.imem_addr, PC_IF2} !== {4'd0, 32'h3C}) begin errors++; $display("FAIL wrap_c0: got %0d/%h exp 0/3c", bus2.imem_addr, PC_IF2); end
        tick();
        checks++; if ({bus2.imem_addr, PC_IF2, instr_IF_ID2, PC_IF_ID2} !== {4'd1, 32'h40, 32'hA000_000F, 32'h3C}) begin errors++; $display("FAIL wrap_c1: got %0d/%h/%h/%h", bus2.imem_addr, PC_IF2, instr_IF_ID2, PC_IF_ID2); end
        tick();
        checks++; if ({PC_IF2, instr_IF_ID2, PC_IF_ID2, PC4_IF_ID2} !== {32'h44, 32'hA000_0000, 32'h40, 32'h44}) begin errors++; $display("FAIL wrap_c2: got %h/%h/%h/%h", PC_IF2, instr_IF_ID2, PC_IF_ID2, PC4_IF_ID2); end
    endtask

    task automatic test_saturation();
        stall2 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall2 = 1'b0;
        checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL stall_sat: got %0d exp 3", stall_cnt2); end
        target2 = 32'h0;
        flush2 = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        flush2 = 1'b0;
        checks++; if ({flush_cnt2, stall_cnt2, valid_IF_ID2} !== {2'd3, 2'd3, 1'b0}) begin errors++; $display("FAIL flush_sat: got %0d/%0d/%b exp 3/3/0", flush_cnt2, stall_cnt2, valid_IF_ID2); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h00100093 + 32'(i);
        for (int i = 0; i < 16; i++) mem2[i] = 32'hA000_0000 + 32'(i);
        reset2 = 1'b1; flush2 = 1'b0; stall2 = 1'b0; target2 = '0;

        test_reset();
        test_sequential();
        test_stall();
        test_flush();
        test_flush_and_stall();
        test_back_to_back();
        test_misalign_halt();
        test_addr_wrap();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
